mic_tdm_ctrl: RTL and testbench

MIC_TDM_CTRL -- requirements
Module: mic_tdm_ctrl

---
 rtl/tdm_pkg.sv | 19 +
 rtl/tdm_clk_div.sv | 51 +++++
 rtl/mic_tdm_ctrl.sv | 149 ++++++++++++++
 tb/tb_mic_tdm_ctrl.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM microphone clocking and receive blocks.
package tdm_pkg;

    // Controller operating states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } tdm_state_e;

    // Default number of serial-clock periods in one TDM slot.
    localparam int TDM_SLOT_BITS_DEFAULT = 32;

    // Width of a counter holding 0..v-1, never less than one bit.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/tdm_clk_div.sv
// Half-period divider generating the TDM serial clock.
// rise_pulse/fall_pulse are strobes meaning "sck_out toggles at the next
// clk_in edge", so the parent can register its own outputs in step with it.
module tdm_clk_div
    import tdm_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic run_in,
    output logic sck_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int DW = clog2_min1(CLK_DIV);

    logic [DW-1:0] cnt_q, cnt_d;
    logic          sck_q, sck_d;
    logic          tc;

    // Next-state of the half-period counter and the serial clock.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        cnt_d      = '0;
        sck_d      = 1'b0;
        tc         = run_in && (cnt_q == DW'(CLK_DIV - 1));
        rise_pulse = tc && !sck_q;
        fall_pulse = tc && sck_q;
        if (run_in) begin
            cnt_d = tc ? '0 : cnt_q + DW'(1);
            sck_d = tc ? ~sck_q : sck_q;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst_in) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

    assign sck_out = sck_q;

endmodule

// File: rtl/mic_tdm_ctrl.sv
// TDM microphone array controller: serial clock, frame sync, slot/bit
// position, warm-up tracking and a clean frame-aligned stop.
module mic_tdm_ctrl
    import tdm_pkg::*;
#(
    parameter int CLK_DIV       = 2,
    parameter int SLOTS         = 2,
    parameter int SLOT_BITS     = TDM_SLOT_BITS_DEFAULT,
    parameter int WARMUP_FRAMES = 4
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         enable_in,
    output logic                         sck_out,
    output logic                         ws_out,
    output logic                         sck_rise_out,
    output logic                         frame_start_out,
    output logic [clog2_min1(SLOTS)-1:0] slot_out,
    output logic [$clog2(SLOT_BITS)-1:0] bit_out,
    output logic                         warm_out,
    output logic                         busy_out
);

    localparam int                FRAME_BITS = SLOTS * SLOT_BITS;
    localparam int                CW         = clog2_min1(FRAME_BITS);
    localparam int                SW         = clog2_min1(SLOTS);
    localparam int                BW         = $clog2(SLOT_BITS);
    localparam logic [CW-1:0]     LAST       = CW'(FRAME_BITS - 1);
    localparam logic [7:0]        WARM_CNT   = 8'(WARMUP_FRAMES);

    tdm_state_e    state_q, state_d;
    logic [CW-1:0] fcnt_q, fcnt_d, fcnt_next;
    logic [7:0]    wcnt_q, wcnt_d;
    logic          seen_q, seen_d;
    logic          ws_q, ws_d;
    logic          rise_q, rise_d;
    logic          fs_q, fs_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          warm_q, warm_d;
    logic          busy_q, busy_d;

    logic          div_sck, div_rise, div_fall;

    tdm_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .run_in     (state_q != ST_IDLE),
        .sck_out    (div_sck),
        .rise_pulse (div_rise),
        .fall_pulse (div_fall)
    );

    // Next-state logic: FSM, frame bit counter, warm-up count, output values.
    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        wcnt_d    = wcnt_q;
        seen_d    = seen_q;
        fcnt_next = (fcnt_q == LAST) ? '0 : fcnt_q + CW'(1);

        case (state_q)
            ST_IDLE: begin
                fcnt_d = '0;
                if (enable_in) begin
                    // Preload so the first serial-clock period carries the frame sync.
                    state_d = ST_RUN;
                    fcnt_d  = LAST;
                end
            end
            ST_RUN: begin
                if (div_fall) fcnt_d = fcnt_next;
                if (!enable_in) state_d = ST_STOPPING;
            end
            ST_STOPPING: begin
                if (enable_in) state_d = ST_RUN;
                if (div_fall) begin
                    // Stop exactly where the next frame sync would begin.
                    if (!enable_in && fcnt_next == LAST) begin
                        state_d = ST_IDLE;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_next;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        fs_d   = div_rise && ws_q;
        rise_d = div_rise;

        // The first frame after start is not counted towards warm-up.
        if (state_d == ST_IDLE) begin
            wcnt_d = '0;
            seen_d = 1'b0;
        end else if (fs_d) begin
            if (!seen_q)               seen_d = 1'b1;
            else if (wcnt_q != WARM_CNT) wcnt_d = wcnt_q + 8'd1;
        end

        busy_d = (state_d != ST_IDLE);
        ws_d   = busy_d && (fcnt_d == LAST);
        slot_d = SW'(32'(fcnt_d) / SLOT_BITS);
        bit_d  = BW'(32'(fcnt_d) % SLOT_BITS);
        warm_d = busy_d && (wcnt_d == WARM_CNT);
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            fcnt_q  <= '0;
            wcnt_q  <= '0;
            seen_q  <= 1'b0;
            ws_q    <= 1'b0;
            rise_q  <= 1'b0;
            fs_q    <= 1'b0;
            slot_q  <= '0;
            bit_q   <= '0;
            warm_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            wcnt_q  <= wcnt_d;
            seen_q  <= seen_d;
            ws_q    <= ws_d;
            rise_q  <= rise_d;
            fs_q    <= fs_d;
            slot_q  <= slot_d;
            bit_q   <= bit_d;
            warm_q  <= warm_d;
            busy_q  <= busy_d;
        end
    end

    assign sck_out         = div_sck;
    assign ws_out          = ws_q;
    assign sck_rise_out    = rise_q;
    assign frame_start_out = fs_q;
    assign slot_out        = slot_q;
    assign bit_out         = bit_q;
    assign warm_out        = warm_q;
    assign busy_out        = busy_q;

endmodule

// File: tb/tb_mic_tdm_ctrl.sv
// Self-checking bench for mic_tdm_ctrl with a timing-arithmetic reference model.
module tb_mic_tdm_ctrl;

    localparam int C   = 2;            // clk_in cycles per sck half-period
    localparam int NS  = 2;            // slots
    localparam int SB  = 32;           // bits per slot
    localparam int W   = 4;            // warm-up frames
    localparam int N   = NS * SB;      // sck periods per frame
    localparam int F   = 2 * C * N;    // clk_in cycles per frame
    localparam int INF = 2147483647;

    logic       clk_in    = 1'b0;
    logic       rst_in    = 1'b1;
    logic       enable_in = 1'b0;
    logic       sck_out, ws_out, sck_rise_out, frame_start_out, warm_out, busy_out;
    logic [0:0] slot_out;
    logic [4:0] bit_out;

    mic_tdm_ctrl #(
        .CLK_DIV       (C),
        .SLOTS         (NS),
        .SLOT_BITS     (SB),
        .WARMUP_FRAMES (W)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .enable_in       (enable_in),
        .sck_out         (sck_out),
        .ws_out          (ws_out),
        .sck_rise_out    (sck_rise_out),
        .frame_start_out (frame_start_out),
        .slot_out        (slot_out),
        .bit_out         (bit_out),
        .warm_out        (warm_out),
        .busy_out        (busy_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic       busy;
        logic       sck;
        logic       ws;
        logic       rise;
        logic       fs;
        logic [0:0] slot;
        logic [4:0] bitn;
        logic       warm;
    } obs_t;

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   t            = -1000000;   // cycles since the RUN-entry edge (negative = idle)
    int   t_stop       = INF;        // cycle at which the model returns to idle
    obs_t got, exp;

    function automatic obs_t observe();
        obs_t o;
        o.busy = busy_out;
        o.sck  = sck_out;
        o.ws   = ws_out;
        o.rise = sck_rise_out;
        o.fs   = frame_start_out;
        o.slot = slot_out;
        o.bitn = bit_out;
        o.warm = warm_out;
        return o;
    endfunction

    // Expected outputs at sample tt: the serial clock runs with period 2*C
    // from the start edge, sck period p carries frame position (N-1+p)%N.
    function automatic obs_t model(input int tt, input int ts);
        obs_t m;
        int   h, p, ctr;
        m = '0;
        if (tt < 0 || tt >= ts) return m;
        h      = tt / C;
        p      = h / 2;
        ctr    = (N - 1 + p) % N;
        m.busy = 1'b1;
        m.sck  = 1'(h % 2);
        m.rise = (tt % C == 0) && (h % 2 == 1);
        m.ws   = (ctr == N - 1);
        m.fs   = m.rise && m.ws;
        m.slot = 1'(ctr / SB);
        m.bitn = 5'(ctr % SB);
        m.warm = (W == 0) || (tt >= (2 * W * N + 1) * C);
        return m;
    endfunction

    task automatic tick();
        @(negedge clk_in);
        t++;
    endtask

    function automatic int stop_cycle(input int t_drop);
        return ((t_drop + 2 + F - 1) / F) * F;
    endfunction

    task automatic test_reset();
        rst_in    = 1'b1;
        enable_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            got = observe();
            tests_run++;
            if (got !== obs_t'(0)) begin
                tests_failed++;
                $display("FAIL reset_hold cycle=%0d got=%b required=%b", i, got, obs_t'(0));
            end
        end
        rst_in = 1'b0;
        t      = -1000000;
        t_stop = INF;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp = model(t, t_stop);
            got = observe();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL idle_after_reset t=%0d got=%b required=%b", t, got, exp);
            end
        end
    endtask

    task automatic test_startup();
        int rises[$];
        int first_rise_fs;
        int gap;
        gap = int'($urandom_range(1, 5));
        for (int i = 0; i < gap; i++) begin
            tick();
            exp = model(t, t_stop);
            got = observe();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL startup_idle t=%0d got=%b required=%b", t, got, exp);
            end
        end
        enable_in     = 1'b1;
        t             = -1;
        t_stop        = INF;
        first_rise_fs = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            exp = model(t, t_stop);
            got = observe();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL startup t=%0d got=%b required=%b", t, got, exp);
            end
            if (got.rise) begin
                if (rises.size() == 0) first_rise_fs = int'(got.fs && got.ws);
                rises.push_back(t);
            end
        end
        tests_run++;
        if (rises.size() < 2 || rises[1] - rises[0] !== 2 * C) begin
            tests_failed++;
            $display("FAIL sck_period got=%0d required=%0d", (rises.size() < 2) ? -1 : rises[1] - rises[0], 2 * C);
        end
        tests_run++;
        if (first_rise_fs !== 1) begin
            tests_failed++;
            $display("FAIL first_rise_frame_start got=%0d required=1", first_rise_fs);
        end
    endtask

    task automatic test_steady_run();
        int fs_times[$];
        int ws_between[$];
        int ws_acc;
        ws_acc = 0;
        for (int i = 0; i < 3 * F; i++) begin
            tick();
            exp = model(t, t_stop);
            got = observe();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL steady t=%0d got=%b required=%b", t, got, exp);
            end
            if (got.fs) begin
                if (fs_times.size() > 0) ws_between.push_back(ws_acc);
                fs_times.push_back(t);
                ws_acc = 0;
            end
            if (got.ws && fs_times.size() > 0) ws_acc++;
        end
        tests_run++;
        if (fs_times.size() < 2) begin
            tests_failed++;
            $display("FAIL frame_count got=%0d required>=2", fs_times.size());
        end
        for (int k = 1; k < fs_times.size(); k++) begin
            tests_run++;
            if (fs_times[k] - fs_times[k-1] !== F) begin
                tests_failed++;
                $display("FAIL frame_interval got=%0d required=%0d", fs_times[k] - fs_times[k-1], F);
            end
            tests_run++;
            if (ws_between[k-1] !== 2 * C) begin
                tests_failed++;
                $display("FAIL ws_cycles_per_frame got=%0d required=%0d", ws_between[k-1], 2 * C);
            end
        end
    endtask

    task automatic test_warmup();
        int n;
        int first_warm;
        int warm_fs;
        first_warm = -1;
        warm_fs    = 0;
        n          = 6 * F + 2 * C - t;
        for (int i = 0; i < n; i++) begin
            tick();
            exp = model(t, t_stop);
            got = observe();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL warmup t=%0d got=%b required=%b", t, got, exp);
            end
            if (got.warm && first_warm < 0) begin
                first_warm = t;
                warm_fs    = int'(got.fs);
            end
        end
        tests_run++;
        if (first_warm !== (2 * W * N + 1) * C || warm_fs !== 1) begin
            tests_failed++;
            $display("FAIL warm_rise got_t=%0d got_fs=%0d required_t=%0d required_fs=1",
                     first_warm, warm_fs, (2 * W * N + 1) * C);
        end
    endtask

    // Runs to the rise sampling slot 1 bit 10; flags a timeout if it never comes.
    task automatic wait_slot1_bit10(input string name);
        int found;
        found = 0;
        for (int i = 0; i < F + 10 && found == 0; i++) begin
            tick();
            exp = model(t, t_stop);
            got = observe();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL %s_seek t=%0d got=%b required=%b", name, t, got, exp);
            end
            if (exp.rise && exp.slot == 1'b1 && exp.bitn == 5'd10) found = 1;
        end
        tests_run++;
        if (found == 0) begin
            tests_failed++;
            $display("FAIL %s_timeout got=none required=slot1_bit10", name);
        end
    endtask

    task automatic test_stop_pulse();
        int d1, d2;
        wait_slot1_bit10("pulse");
        enable_in = 1'b0;
        d1 = int'($urandom_range(3, 20));
        d2 = int'($urandom_range(3, 20));
        for (int i = 0; i < d1 + 1 + d2 + F; i++) begin
            tick();
            if (i == d1 - 1)      enable_in = 1'b1;
            if (i == d1)          enable_in = 1'b0;
            if (i == d1 + d2)     enable_in = 1'b1;
            exp = model(t, t_stop);
            got = observe();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL stop_pulse t=%0d got=%b required=%b", t, got, exp);
            end
        end
    endtask

    task automatic test_stop();
        int n;
        wait_slot1_bit10("stop");
        enable_in = 1'b0;
        t_stop    = stop_cycle(t);
        n         = t_stop + 20 - t;
        for (int i = 0; i < n; i++) begin
            tick();
            exp = model(t, t_stop);
            got = observe();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL stop t=%0d got=%b required=%b", t, got, exp);
            end
        end
    endtask

    task automatic test_random_restarts();
        int gap, len, n;
        for (int r = 0; r < 3; r++) begin
            gap = int'($urandom_range(1, 8));
            len = int'($urandom_range(50, 700));
            for (int i = 0; i < gap; i++) begin
                tick();
                exp = model(t, t_stop);
                got = observe();
                tests_run++;
                if (got !== exp) begin
                    tests_failed++;
                    $display("FAIL restart_idle r=%0d t=%0d got=%b required=%b", r, t, got, exp);
                end
            end
            enable_in = 1'b1;
            t         = -1;
            t_stop    = INF;
            for (int i = 0; i < len; i++) begin
                tick();
                exp = model(t, t_stop);
                got = observe();
                tests_run++;
                if (got !== exp) begin
                    tests_failed++;
                    $display("FAIL restart_run r=%0d t=%0d got=%b required=%b", r, t, got, exp);
                end
            end
            enable_in = 1'b0;
            t_stop    = stop_cycle(t);
            n         = t_stop + 10 - t;
            for (int i = 0; i < n; i++) begin
                tick();
                exp = model(t, t_stop);
                got = observe();
                tests_run++;
                if (got !== exp) begin
                    tests_failed++;
                    $display("FAIL restart_stop r=%0d t=%0d got=%b required=%b", r, t, got, exp);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int len;
        len       = int'($urandom_range(100, 400));
        enable_in = 1'b1;
        t         = -1;
        t_stop    = INF;
        for (int i = 0; i < len; i++) begin
            tick();
            exp = model(t, t_stop);
            got = observe();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL pre_reset_run t=%0d got=%b required=%b", t, got, exp);
            end
        end
        // Assert reset between clock edges and look before the next edge.
        #2 rst_in = 1'b1;
        #1 got = observe();
        tests_run++;
        if (got !== obs_t'(0)) begin
            tests_failed++;
            $display("FAIL async_reset got=%b required=%b", got, obs_t'(0));
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            got = observe();
            tests_run++;
            if (got !== obs_t'(0)) begin
                tests_failed++;
                $display("FAIL reset_held cycle=%0d got=%b required=%b", i, got, obs_t'(0));
            end
        end
        rst_in = 1'b0;
        t      = -1;
        t_stop = INF;
        for (int i = 0; i < 300; i++) begin
            tick();
            exp = model(t, t_stop);
            got = observe();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL post_reset t=%0d got=%b required=%b", t, got, exp);
            end
        end
        enable_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_startup();
        test_steady_run();
        test_warmup();
        test_stop_pulse();
        test_stop();
        test_random_restarts();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
